// File: rtl/regfile_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writer_pkg : shared widths, load funct3 codes, FSM states    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package regfile_writer_pkg;

  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;

  localparam logic [RegLen-1:0]     ZERO_WORD = '0;
  localparam logic [RegAddrLen-1:0] X0        = '0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Byte count of a load; 0 marks an illegal funct3.
  function automatic logic [2:0] load_len(input logic [2:0] f3);
    case (f3)
      LB, LBU: load_len = 3'd1;
      LH, LHU: load_len = 3'd2;
      LW:      load_len = 3'd4;
      default: load_len = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writer_load_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writer_load_ext : sign/zero extension of assembled load bytes|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_writer_load_ext
  import regfile_writer_pkg::*;
#(
  parameter int XLEN = RegLen
) (
  input  logic [31:0]     bytes_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      LB:      data_o = XLEN'($signed(bytes_i[7:0]));
      LH:      data_o = XLEN'($signed(bytes_i[15:0]));
      LW:      data_o = XLEN'($signed(bytes_i));
      LBU:     data_o = XLEN'(bytes_i[7:0]);
      LHU:     data_o = XLEN'(bytes_i[15:0]);
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writer : write-back stage, ALU pass-through and byte loads.  |
// | Option macro REGFILE_WRITER_PEND_EN adds pending-load outputs.       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int XLEN       = RegLen,
  parameter int REG_ADDR_W = RegAddrLen
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rd_en,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_result,
  output logic                  mem_req,
  output logic [XLEN-1:0]       mem_addr,
  input  logic [7:0]            mem_din,
  output logic                  rd_enable_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
`ifdef REGFILE_WRITER_PEND_EN
  output logic                  pend_valid_o,
  output logic [REG_ADDR_W-1:0] pend_addr_o,
`endif
  output logic                  err_o
);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   rd_addr_q;
  logic                    wen_q;
  logic                    alu_wr_q;
  logic [XLEN-1:0]         result_q;
  logic                    err_q;
  logic [XLEN-1:0]         base_q;
  logic [2:0]              funct3_q;
  logic [2:0]              nbytes_q;
  logic [2:0]              cnt_q;
  logic [3:0][7:0]         lanes_q;

  logic                    accept;
  logic [2:0]              in_len;
  logic                    in_wen;
  logic [1:0]              cap_lane;
  logic                    commit_wr;
  logic [XLEN-1:0]         ext_data;

  assign accept   = in_valid && in_ready;
  assign in_len   = load_len(in_funct3);
  assign in_wen   = in_rd_en && (in_rd_addr != REG_ADDR_W'(X0));
  // Lane filled this cycle is the one addressed in the previous cycle.
  assign cap_lane = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        if (accept && in_is_load && (in_len != 3'd0)) state_d = ST_LOAD;
        else                                          state_d = ST_IDLE;
      end
      ST_LOAD: if (cnt_q == nbytes_q) state_d = ST_COMMIT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !rst && (state_q != ST_LOAD);
    mem_req     = (state_q == ST_LOAD) && (cnt_q < nbytes_q);
    mem_addr    = mem_req ? base_q + XLEN'(cnt_q) : '0;
    commit_wr   = (state_q == ST_COMMIT) && wen_q;
    rd_enable_o = alu_wr_q || commit_wr;
    rd_addr_o   = rd_enable_o ? rd_addr_q : '0;
    rd_data_o   = alu_wr_q ? result_q : (commit_wr ? ext_data : '0);
    err_o       = err_q;
  end

`ifdef REGFILE_WRITER_PEND_EN
  always_comb begin
    pend_valid_o = (state_q == ST_LOAD) && wen_q;
    pend_addr_o  = pend_valid_o ? rd_addr_q : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      wen_q     <= 1'b0;
      alu_wr_q  <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      base_q    <= '0;
      funct3_q  <= '0;
      nbytes_q  <= '0;
      cnt_q     <= '0;
      lanes_q   <= '0;
    end else begin
      alu_wr_q <= 1'b0;
      err_q    <= 1'b0;
      if (accept) begin
        rd_addr_q <= in_rd_addr;
        wen_q     <= in_wen;
        if (!in_is_load) begin
          alu_wr_q <= in_wen;
          result_q <= in_result;
        end else if (in_len == 3'd0) begin
          err_q <= 1'b1;
        end else begin
          base_q   <= in_addr;
          funct3_q <= in_funct3;
          nbytes_q <= in_len;
          cnt_q    <= '0;
          lanes_q  <= '0;
        end
      end
      if (state_q == ST_LOAD) begin
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q != 3'd0) lanes_q[cap_lane] <= mem_din;
      end
    end
  end

  regfile_writer_load_ext #(.XLEN(XLEN)) u_load_ext (
    .bytes_i  (lanes_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_writer : directed vectors and corner sequences            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_regfile_writer;
  import regfile_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_rd_en;
  logic [4:0]  in_rd_addr;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_result;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic        rd_enable_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        err_o;
`ifdef REGFILE_WRITER_PEND_EN
  logic        pend_valid_o;
  logic [4:0]  pend_addr_o;
`endif

  regfile_writer #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd_en    (in_rd_en),
    .in_rd_addr  (in_rd_addr),
    .in_is_load  (in_is_load),
    .in_funct3   (in_funct3),
    .in_addr     (in_addr),
    .in_result   (in_result),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .rd_enable_o (rd_enable_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
`ifdef REGFILE_WRITER_PEND_EN
    .pend_valid_o(pend_valid_o),
    .pend_addr_o (pend_addr_o),
`endif
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  always @(posedge clk) if (mem_req) mem_din <= ram[mem_addr[9:0]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;     // ALU result, or RAM bytes little-endian for loads
    logic        exp_wr;
    logic [31:0] exp_data;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic is_load, input logic [2:0] f3, input logic rd_en,
                              input logic [4:0] rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic exp_wr,
                              input logic [31:0] exp_data, input int exp_n,
                              input logic exp_err);
    vec_t v;
    v.is_load = is_load; v.f3 = f3; v.rd_en = rd_en; v.rd = rd; v.addr = addr;
    v.data = data; v.exp_wr = exp_wr; v.exp_data = exp_data; v.exp_n = exp_n;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input logic is_load, input logic [2:0] f3, input logic rd_en,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] res);
    in_valid = 1'b1; in_is_load = is_load; in_funct3 = f3; in_rd_en = rd_en;
    in_rd_addr = rd; in_addr = addr; in_result = res;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Starts one cycle after a rising edge with in_valid low.
  task automatic run_vec(input int id, input vec_t v);
    int nreq, nwr, wcyc, nerr, nbusy, npend;
    logic [31:0] wdata, a;
    logic [4:0]  waddr;
    nreq = 0; nwr = 0; wcyc = 0; nerr = 0; nbusy = 0; npend = 0;
    wdata = '0; waddr = '0;
    if (v.is_load) begin
      for (int i = 0; i < 4; i++) begin
        a = v.addr + 32'(i);
        ram[a[9:0]] = v.data[8*i +: 8];
      end
    end
    check($sformatf("v%0d ready_at_issue", id), {31'd0, in_ready}, 32'd1);
    drive(v.is_load, v.f3, v.rd_en, v.rd, v.addr, v.data);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_req) begin
        check($sformatf("v%0d mem_addr%0d", id, nreq), mem_addr, v.addr + 32'(nreq));
        nreq++;
      end
      if (rd_enable_o) begin
        nwr++; wcyc = c; wdata = rd_data_o; waddr = rd_addr_o;
      end
      if (err_o) nerr++;
      if (!in_ready) nbusy++;
`ifdef REGFILE_WRITER_PEND_EN
      if (pend_valid_o) begin
        npend++;
        check($sformatf("v%0d pend_addr", id), {27'd0, pend_addr_o}, {27'd0, v.rd});
      end
`endif
      next_cycle();
    end
    check($sformatf("v%0d write_count", id), nwr, v.exp_wr ? 1 : 0);
    if (v.exp_wr) begin
      check($sformatf("v%0d rd_data", id), wdata, v.exp_data);
      check($sformatf("v%0d rd_addr", id), {27'd0, waddr}, {27'd0, v.rd});
      check($sformatf("v%0d write_cycle", id), wcyc, (v.exp_n > 0) ? v.exp_n + 2 : 1);
    end
    check($sformatf("v%0d req_count", id), nreq, v.exp_n);
    check($sformatf("v%0d err_count", id), nerr, v.exp_err ? 1 : 0);
    check($sformatf("v%0d busy_cycles", id), nbusy, (v.exp_n > 0) ? v.exp_n + 1 : 0);
`ifdef REGFILE_WRITER_PEND_EN
    check($sformatf("v%0d pend_cycles", id), npend,
          (v.exp_wr && v.exp_n > 0) ? v.exp_n + 1 : 0);
`else
    if (npend != 0) check($sformatf("v%0d pend_cycles", id), npend, 0);
`endif
  endtask

  vec_t tbl[16];

  initial begin
    int nwr;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    tbl[0]  = mk(1'b0, 3'b000, 1'b1, 5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0, 1'b0);
    tbl[1]  = mk(1'b1, LW,     1'b1, 5'd7,  32'h100,      32'h44332211, 1'b1, 32'h44332211, 4, 1'b0);
    tbl[2]  = mk(1'b1, LB,     1'b1, 5'd8,  32'h200,      32'h00000080, 1'b1, 32'hFFFFFF80, 1, 1'b0);
    tbl[3]  = mk(1'b1, LBU,    1'b1, 5'd9,  32'h200,      32'h00000080, 1'b1, 32'h00000080, 1, 1'b0);
    tbl[4]  = mk(1'b1, LH,     1'b1, 5'd10, 32'h300,      32'h00008000, 1'b1, 32'hFFFF8000, 2, 1'b0);
    tbl[5]  = mk(1'b1, LHU,    1'b1, 5'd11, 32'h302,      32'h0000F234, 1'b1, 32'h0000F234, 2, 1'b0);
    tbl[6]  = mk(1'b1, LB,     1'b1, 5'd12, 32'h201,      32'h0000007F, 1'b1, 32'h0000007F, 1, 1'b0);
    tbl[7]  = mk(1'b1, LW,     1'b1, 5'd0,  32'h100,      32'h44332211, 1'b0, 32'h0,        4, 1'b0);
    tbl[8]  = mk(1'b1, 3'b011, 1'b1, 5'd3,  32'h140,      32'h0,        1'b0, 32'h0,        0, 1'b1);
    tbl[9]  = mk(1'b1, 3'b110, 1'b1, 5'd4,  32'h140,      32'h0,        1'b0, 32'h0,        0, 1'b1);
    tbl[10] = mk(1'b1, 3'b111, 1'b1, 5'd4,  32'h140,      32'h0,        1'b0, 32'h0,        0, 1'b1);
    tbl[11] = mk(1'b0, 3'b000, 1'b0, 5'd6,  32'h0,        32'h12345678, 1'b0, 32'h0,        0, 1'b0);
    tbl[12] = mk(1'b0, 3'b000, 1'b1, 5'd0,  32'h0,        32'hCAFEF00D, 1'b0, 32'h0,        0, 1'b0);
    tbl[13] = mk(1'b1, LH,     1'b1, 5'd13, 32'hFFFFFFFF, 32'h00008001, 1'b1, 32'hFFFF8001, 2, 1'b0);
    tbl[14] = mk(1'b1, LW,     1'b1, 5'd31, 32'h00000FFD, 32'h8899AABB, 1'b1, 32'h8899AABB, 4, 1'b0);
    tbl[15] = mk(1'b1, LHU,    1'b0, 5'd14, 32'h180,      32'h0000ABCD, 1'b0, 32'h0,        2, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_rd_en = 1'b0; in_rd_addr = '0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr = '0; in_result = '0;
    repeat (3) next_cycle();
    check("ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; #1;
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_mem_req",   {31'd0, mem_req},     32'd0);
    check("rst_mem_addr",  mem_addr,             ZERO_WORD);
    check("rst_rd_enable", {31'd0, rd_enable_o}, 32'd0);
    check("rst_rd_addr",   {27'd0, rd_addr_o},   32'd0);
    check("rst_rd_data",   rd_data_o,            ZERO_WORD);
    check("rst_err",       {31'd0, err_o},       32'd0);
    next_cycle();

    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // Reset in cycle E+2 of a word load.
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    drive(1'b1, LW, 1'b1, 5'd7, 32'h100, 32'h0);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    check("mid_rst_addr_e2", mem_addr, 32'h101);
    rst = 1'b1; #1;
    check("mid_rst_ready_low", {31'd0, in_ready}, 32'd0);
    next_cycle();
    rst = 1'b0; #1;
    check("mid_rst_req_drop", {31'd0, mem_req}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    nwr = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_enable_o || mem_req) nwr++;
      next_cycle();
    end
    check("mid_rst_no_activity", nwr, 0);

    // ALU accepted in the COMMIT cycle of a byte load, then another ALU.
    ram[10'h200] = 8'h80;
    drive(1'b1, LB, 1'b1, 5'd8, 32'h200, 32'h0);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("b2b_load_en",   {31'd0, rd_enable_o}, 32'd1);
    check("b2b_load_data", rd_data_o,            32'hFFFFFF80);
    check("b2b_load_addr", {27'd0, rd_addr_o},   32'd8);
    check("b2b_commit_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 3'b000, 1'b1, 5'd20, 32'h0, 32'h0000BEEF);
    next_cycle();
    check("b2b_alu1_en",   {31'd0, rd_enable_o}, 32'd1);
    check("b2b_alu1_addr", {27'd0, rd_addr_o},   32'd20);
    check("b2b_alu1_data", rd_data_o,            32'h0000BEEF);
    drive(1'b0, 3'b000, 1'b1, 5'd21, 32'h0, 32'h00000001);
    next_cycle();
    in_valid = 1'b0;
    check("b2b_alu2_addr", {27'd0, rd_addr_o},   32'd21);
    check("b2b_alu2_data", rd_data_o,            32'h00000001);
    next_cycle();
    check("b2b_idle_en",   {31'd0, rd_enable_o}, 32'd0);
    check("b2b_idle_data", rd_data_o,            32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_writer.md
# regfile_writer

Write-back stage that drives the integer register file's write port (rd enable/address/data) from results leaving the memory stage. ALU results pass through a one-cycle pipeline register. Loads fetch 1, 2 or 4 bytes little-endian from the byte-wide data RAM (address in cycle n, data valid in cycle n+1), then sign- or zero-extend and commit. It sits between the MEM stage and the register file, and is the only writer of the register file.

## Interface
Parameters:
- XLEN, 32, data/address width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_rd_en  in  1  instruction writes rd.
- in_rd_addr  in  REG_ADDR_W  destination register.
- in_is_load  in  1  1 = load, 0 = ALU result.
- in_funct3  in  3  load width/sign code.
- in_addr  in  XLEN  load effective address.
- in_result  in  XLEN  ALU result (ignored for loads).
- mem_req  out  1  byte read request this cycle.
- mem_addr  out  XLEN  byte address.
- mem_din  in  8  read data for the address presented in the previous cycle.
- rd_enable_o  out  1  register-file write strobe.
- rd_addr_o  out  REG_ADDR_W  write address.
- rd_data_o  out  XLEN  write data.
- err_o  out  1  one-cycle pulse on illegal load funct3.

## Operation
- FSM states: IDLE, LOAD (issuing/collecting bytes), COMMIT.
- in_ready = 1 in IDLE and COMMIT, 0 in LOAD. An instruction is accepted on an edge where in_valid && in_ready.
- ALU accept: registers result; next cycle rd_enable_o = in_rd_en && (in_rd_addr != 0), rd_addr_o/rd_data_o hold the captured values. State stays IDLE.
- Load accept: latches base address, funct3 and rd; byte count N = 1 (LB 000, LBU 100), 2 (LH 001, LHU 101), 4 (LW 010); goes to LOAD with k = 0.
- LOAD: mem_req = 1 and mem_addr = base + k while k < N. mem_din is captured into byte lane k-1 in the cycle after address k-1 was issued. After lane N-1 is captured, go to COMMIT.
- COMMIT: outputs the extended value for one cycle. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Returns to IDLE, or accepts a new instruction in the same cycle.
- Illegal funct3 (011, 110, 111) with in_is_load: no memory access, no write; err_o pulses in the cycle after acceptance.
- rd = x0 or in_rd_en = 0: the load still performs its reads, but rd_enable_o stays 0.
- No alignment check; a misaligned access is read byte-wise, wrap-around at 2^XLEN.
- Outside write cycles, rd_enable_o = 0. rd_addr_o/rd_data_o are 0 whenever rd_enable_o = 0.

## Timing
- Reset values: in_ready 0 in the reset cycle, then 1; mem_req 0; mem_addr 0; rd_enable_o 0; rd_addr_o 0; rd_data_o 0; err_o 0; FSM IDLE; byte lanes 0.
- ALU latency: accept edge E → write visible in the cycle after E. Throughput: 1 per cycle.
- Load latency for N bytes: addresses in cycles E+1 … E+N; bytes captured at the ends of cycles E+2 … E+N+1; write visible in cycle E+N+2.
- Reset mid-load: abort next edge, discard partial bytes, no write; mem_req drops the cycle after reset is sampled.
- in_valid held while in_ready = 0: inputs must stay stable (MEM-stage obligation); the block does not buffer.

## Configuration
- REGFILE_WRITER_PEND_EN defined:
  - Adds outputs pend_valid_o (1) and pend_addr_o (REG_ADDR_W).
  - pend_valid_o = 1 from the accept edge of a load with rd ≠ 0 until the cycle before COMMIT; pend_addr_o = that rd. This lets decode stall on a load-use hazard.
  - Both outputs are 0 on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Shared package:
  - RegLen, RegAddrLen, ZERO_WORD, X0.
  - Load funct3 constants LB/LH/LW/LBU/LHU.
  - FSM state enum.
- Sub-module load_ext: combinational; takes the 4 assembled bytes and funct3, returns the XLEN extended value. Unit-testable alone.

## Test plan
- ALU: accept rd=5, result 0xDEADBEEF at E → cycle E+1: rd_enable_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; E+2: rd_enable_o=0.
- LW from 0x100, RAM bytes 11 22 33 44 → mem_addr 0x100..0x103 in cycles E+1..E+4; in_ready 0 throughout; write 0x44332211 to rd in cycle E+6.
- LB from 0x200 = 0x80 → rd_data 0xFFFFFF80. LBU → 0x00000080. LH of bytes 00 80 → 0xFFFF8000.
- Load with rd=0, then funct3=011 → memory reads occur for the first, no rd_enable_o for either; err_o pulses once for the second, with no mem_req.
- rst asserted in cycle E+2 of an LW → no write, mem_req 0 from the next cycle, in_ready 1 after reset releases.
- Back-to-back: ALU accepted in the COMMIT cycle of a load → the load is written, then the ALU result is written in the next cycle.
